// File: rtl/mem_access_sched.sv
// Shares one single-port synchronous memory between instruction fetch and the
// load/store path using a fixed-latency access sequence and anti-starvation arbitration.
module mem_access_sched #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt_in,
  output logic              halted,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  logic [2:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        owner_if;
  logic        owner_we;
  logic        halt_seen;

  logic        dm_pend;
  logic        grant_if;
  logic        grant_dm;
  logic        take_grant;
  logic        capture;
  logic        mem_en_nxt;
  logic        mem_we_nxt;
  logic        if_done_nxt;
  logic        dm_done_nxt;
  logic        halted_nxt;

  // Fetch wins only when the load/store path has used up its streak allowance.
  assign dm_pend    = dm_rd | dm_wr;
  assign grant_if   = if_req & (~dm_pend | (starve_cnt == STARVE_TOP));
  assign grant_dm   = dm_pend & ~grant_if;
  assign take_grant = (state == ST_IDLE) & ~halt_in & (if_req | dm_pend);
  assign capture    = (state == ST_WAIT) & (lat_cnt == 3'd0);

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_pend & ~dm_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (halt_in) begin
          state_nxt = ST_HALTED;
        end else if (if_req | dm_pend) begin
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (lat_cnt == 3'd0) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      // A halt seen at any point during the access parks the scheduler after completion.
      ST_DONE: begin
        if (halt_seen | halt_in) begin
          state_nxt = ST_HALTED;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en_nxt  = take_grant;
    mem_we_nxt  = take_grant & grant_dm & dm_wr;
    if_done_nxt = capture & owner_if;
    dm_done_nxt = capture & ~owner_if;
    halted_nxt  = (state_nxt == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      halted     <= 1'b0;
      proto_err  <= 1'b0;
      owner_if   <= 1'b0;
      owner_we   <= 1'b0;
      halt_seen  <= 1'b0;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
    end else begin
      mem_en  <= mem_en_nxt;
      mem_we  <= mem_we_nxt;
      if_done <= if_done_nxt;
      dm_done <= dm_done_nxt;
      halted  <= halted_nxt;

      if (take_grant) begin
        owner_if  <= grant_if;
        owner_we  <= grant_dm & dm_wr;
        mem_addr  <= grant_if ? if_addr : dm_addr;
        mem_wdata <= grant_if ? '0 : dm_wdata;
        lat_cnt   <= LAT_INIT;
        halt_seen <= 1'b0;
        if (grant_dm & dm_rd & dm_wr) begin
          proto_err <= 1'b1;
        end
        // Streak counter only advances while fetch is actually waiting.
        if (grant_if | ~if_req) begin
          starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_TOP) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        if (((state == ST_ISSUE) | (state == ST_WAIT)) & (lat_cnt != 3'd0)) begin
          lat_cnt <= lat_cnt - 3'd1;
        end
        if (halt_in & ((state == ST_ISSUE) | (state == ST_WAIT))) begin
          halt_seen <= 1'b1;
        end
      end

      if (capture & owner_if) begin
        if_rdata <= mem_rdata;
      end
      if (capture & ~owner_if & ~owner_we) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sched.sv
// Bench for mem_access_sched: directed scenarios plus randomized traffic, checked
// against a transaction-phase reference model and a behavioural memory.
module tb_mem_access_sched;

  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam int DN   = LAT + 2;

  logic        clk = 1'b0;
  logic        reset, load_mem;
  logic        if_req, if_done, dm_rd, dm_wr, dm_done;
  logic [8:0]  if_addr, dm_addr, mem_addr;
  logic [31:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;
  logic        if_stall, dm_stall, mem_en, mem_we, halt_in, halted, proto_err;

  int n_total = 0;
  int n_bad   = 0;

  mem_access_sched #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .if_stall(if_stall), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .halt_in(halt_in), .halted(halted), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Behavioural single-port memory; read data appears LAT cycles after the strobe.
  logic [31:0] mem [0:511];
  logic [31:0] pipe [0:LAT-1];
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: m_t is the cycle index within the current access (0 = none).
  logic [31:0] mm [0:511];
  int          m_t, m_starve;
  bit          m_if, m_we, m_halt, m_hseen, m_proto;
  logic [8:0]  m_maddr;
  logic [31:0] e_ifr, e_dmr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_t = 0; m_halt = 0; m_hseen = 0; m_proto = 0; m_starve = 0;
      e_ifr = '0; e_dmr = '0; m_maddr = '0;
    end else if (!m_halt) begin
      if (m_t == 0) begin
        if (halt_in) begin
          m_halt = 1;
        end else if (if_req || dm_rd || dm_wr) begin
          m_if = if_req && (!(dm_rd || dm_wr) || m_starve == SMAX);
          if (m_if) begin
            m_starve = 0; m_we = 0; m_maddr = if_addr;
          end else begin
            m_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
            m_we = dm_wr; m_maddr = dm_addr;
            if (dm_rd && dm_wr) m_proto = 1;
            if (dm_wr) mm[dm_addr] = dm_wdata;
          end
          m_t = 1;
        end
      end else if (m_t < DN) begin
        if (halt_in) m_hseen = 1;
        m_t++;
        if (m_t == DN && !m_we) begin
          if (m_if) e_ifr = mm[m_maddr];
          else      e_dmr = mm[m_maddr];
        end
      end else begin
        if (halt_in || m_hseen) m_halt = 1;
        m_hseen = 0;
        m_t = 0;
      end
    end
  endtask

  task automatic check_all();
    bit exp_en, done_if, done_dm;
    exp_en  = (m_t == 1);
    done_if = (m_t == DN) && m_if;
    done_dm = (m_t == DN) && !m_if;
    check_val("mem_en",    32'(mem_en),    32'(exp_en));
    check_val("mem_we",    32'(mem_we),    32'(exp_en && m_we));
    check_val("mem_addr",  32'(mem_addr),  32'(m_maddr));
    if (exp_en && m_we) check_val("mem_wdata", mem_wdata, mm[m_maddr]);
    check_val("if_done",   32'(if_done),   32'(done_if));
    check_val("dm_done",   32'(dm_done),   32'(done_dm));
    check_val("if_rdata",  if_rdata,       e_ifr);
    check_val("dm_rdata",  dm_rdata,       e_dmr);
    check_val("halted",    32'(halted),    32'(m_halt));
    check_val("proto_err", 32'(proto_err), 32'(m_proto));
    check_val("if_stall",  32'(if_stall),  32'(if_req && !done_if));
    check_val("dm_stall",  32'(dm_stall),  32'((dm_rd || dm_wr) && !done_dm));
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_done(input int maxc);
    int c;
    c = 0;
    while (m_t != DN && c < maxc) begin
      step();
      c++;
    end
    if (m_t != DN) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  int k, last_cyc, hold;

  initial begin
    for (int i = 0; i < 512; i++) mm[i] = init_word(i);
    m_t = 0; m_if = 0; m_we = 0;
    reset = 1'b1; load_mem = 1'b1; halt_in = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    step();
    load_mem = 1'b0;
    step();
    check_val("rst_wdata", mem_wdata, 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);

    // Fetch of the preloaded word
    reset = 1'b0; if_req = 1'b1; if_addr = 9'd5;
    for (int c = 0; c < DN; c++) step();
    check_val("fetch_done", 32'(if_done), 32'd1);
    check_val("fetch_data", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;

    // Store then load back
    dm_wr = 1'b1; dm_addr = 9'd3; dm_wdata = 32'h12345678;
    step();
    run_until_done(DN + 2);
    dm_wr = 1'b0; dm_rd = 1'b1;
    step();
    run_until_done(DN + 2);
    check_val("load_back", dm_rdata, 32'h12345678);
    check_val("no_proto", 32'(proto_err), 32'd0);
    dm_rd = 1'b0;

    // Contention: four loads then one fetch, strobes five cycles apart
    reset = 1'b1; step(); reset = 1'b0;
    if_req = 1'b1; if_addr = 9'd7; dm_rd = 1'b1; dm_addr = 9'd3;
    k = 0; last_cyc = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (mem_en) begin
        check_val("grant_order", 32'(mem_addr), (k % 5 == 4) ? 32'd7 : 32'd3);
        if (k > 0) check_val("grant_gap", 32'(c - last_cyc), 32'(LAT + 3));
        last_cyc = c;
        k++;
      end
    end
    check_val("grant_count", 32'(k), 32'd12);
    if_req = 1'b0; dm_rd = 1'b0;

    // Halt pulse in the wait cycle of a load
    reset = 1'b1; step(); reset = 1'b0;
    dm_rd = 1'b1; dm_addr = 9'd3;
    step(); step();
    halt_in = 1'b1; step(); halt_in = 1'b0;
    step();
    check_val("halt_load_done", 32'(dm_done), 32'd1);
    check_val("halt_load_data", dm_rdata, 32'h12345678);
    dm_rd = 1'b0; if_req = 1'b1; if_addr = 9'd5;
    step();
    check_val("halted_set", 32'(halted), 32'd1);
    for (int c = 0; c < 10; c++) step();

    // Reset during the wait cycle aborts, then the held fetch restarts
    reset = 1'b1; step(); reset = 1'b0;
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    check_val("abort_done", 32'(if_done), 32'd0);
    for (int c = 0; c < DN; c++) step();
    check_val("refetch_done", 32'(if_done), 32'd1);
    check_val("refetch_data", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;

    // Read and write together: the write happens and the error flag sticks
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 9'd9; dm_wdata = 32'hAAAA5555;
    step();
    run_until_done(DN + 2);
    check_val("proto_set", 32'(proto_err), 32'd1);
    dm_rd = 1'b0; dm_wr = 1'b0;
    for (int c = 0; c < 8; c++) step();
    check_val("proto_sticky", 32'(proto_err), 32'd1);

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = 1'b0;
      if (m_t == DN && m_if) if_req = ($urandom_range(0, 3) == 0);
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      if ((m_t == DN && !m_if) || !(dm_rd || dm_wr)) begin
        dm_rd = 1'b0; dm_wr = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 15))
            0:       begin dm_rd = 1'b1; dm_wr = 1'b1; end
            1, 2, 3, 4, 5, 6: dm_wr = 1'b1;
            default: dm_rd = 1'b1;
          endcase
        end
      end
      if_addr  = 9'($urandom_range(0, 15));
      dm_addr  = 9'($urandom_range(0, 15));
      dm_wdata = $urandom;
      halt_in  = ($urandom_range(0, 60) == 0);
      if (m_halt) hold++;
      if ((m_halt && hold > 3) || $urandom_range(0, 300) == 0) begin
        reset = 1'b1; hold = 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
